pcie_trans_nch: RTL and testbench
=================================

Name: pcie_trans_nch

Overview:
Parametrised next-generation PCIe transaction-layer router.
- Words are pushed into one main FIFO and routed by a destination field to NUM_DEST destination FIFOs.
- Each destination FIFO has its own pop/can_pop handshake.
- Threshold-based backpressure (main_pause) and a supervisory FSM with a sticky ERROR state.
- Sits between the link-side producer (the probador in benches) and the N consumer ports.
- Generalises the fixed 2-destination, 6-bit design to any width and destination count.

Parameters:
- WIDTH, 8: data word width in bits.
- DEST_BITS, 2: width of the destination field. NUM_DEST = 2**DEST_BITS.
- DEPTH, 8: entries per FIFO (main and each destination); power of 2.
- LENGTH, 4: width of thresholds and occupancy counts, equal to log2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- init  in  1  when high in INIT, thresholds are (re)loaded.
- data_in  in  WIDTH  word to push; destination = data_in[WIDTH-1 -: DEST_BITS].
- push  in  1  write data_in into the main FIFO.
- pop  in  NUM_DEST  per-destination read request.
- umbral_main  in  LENGTH  main FIFO almost-full threshold.
- umbral_dest  in  LENGTH  destination FIFO almost-full threshold, common to all destinations.
- data_out  out  NUM_DEST*WIDTH  slice i = last word popped from destination i.
- can_pop  out  NUM_DEST  bit i = destination FIFO i non-empty.
- main_pause  out  1  main FIFO occupancy >= threshold.
- error_out  out  1  high while in ERROR.
- idle_out  out  1  high while in IDLE.
- state  out  4  current FSM state.
- next_state  out  4  combinational next FSM state.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All pointers and counts go to 0 and latched thresholds go to 0.
  - data_out = 0; state = RESET.
  - Outputs during reset: can_pop = 0, main_pause = 0, error_out = 0, idle_out = 0.
  - Reset mid-operation discards all stored words.
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- FSM transitions:
  - RESET -> INIT on the first cycle with reset==1.
  - INIT: latch umbral_main and umbral_dest every cycle while init==1. Go to IDLE when init==0.
  - IDLE <-> ACTIVE: ACTIVE when any FIFO is non-empty, IDLE when all FIFOs are empty.
  - Any non-RESET state -> ERROR on an overflow or underflow event (defined below).
  - ERROR is sticky until reset. FIFOs keep operating in ERROR.
- Push and pop are ignored in RESET and INIT.
- Main FIFO:
  - push with count<DEPTH stores data_in.
  - push with count==DEPTH: word dropped, overflow event.
  - Simultaneous push and internal transfer when full is accepted; count is unchanged.
- Routing:
  - At most one word per cycle moves from the main head to the destination FIFO d named by the head's field.
  - Transfer condition: main non-empty and dest_count[d] < umbral_dest_latched.
  - Otherwise the head blocks (strict head-of-line; no bypass).
  - The transferred word is visible in destination d the cycle after the transfer.
  - Push-to-earliest-can_pop latency = 2 cycles.
- Destination pop:
  - pop[i] with can_pop[i]==1: data_out slice i takes the head word at the next edge (1-cycle latency) and count decrements.
  - pop[i] with can_pop[i]==0: underflow event; data_out holds.
  - data_out slices hold their value when not popped.
  - Transfer-in and pop on the same destination in the same cycle is allowed; count is unchanged.
- main_pause:
  - Combinational: main_count >= umbral_main_latched.
  - A latched threshold of 0 means always paused.
  - A paused producer must stop pushing; the block does not enforce this except via overflow.
- Counts and pointers:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Counts are LENGTH bits and saturate only by construction.

Decomposition:
- Package pcie_trans_pkg holds:
  - state encodings ST_RESET..ST_ERROR;
  - default WIDTH, DEST_BITS, DEPTH, LENGTH;
  - the destination-field extraction function.
- Sub-module fifo_sync:
  - parameters WIDTH, DEPTH, LENGTH;
  - ports: push, pop, data_in, data_out, count, empty, full, and overflow/underflow pulses;
  - instantiated 1+NUM_DEST times via generate.
- The top level holds the FSM, router, threshold latches and output registers.

Test Plan:
- Reset and init: reset=0 for 2 cycles, then init=1 with umbral_main=6, umbral_dest=3, then init=0 -> state 0 -> 1 -> 2, all outputs 0, idle_out=1.
- Routing: push 8'h05, 8'h4A, 8'h8F, 8'hC3 on consecutive cycles -> can_pop = 4'b0001, 0011, 0111, 1111 on cycles 2..5 after the first push; popping each returns the matching word 1 cycle later; state returns to IDLE.
- Head-of-line backpressure: with umbral_dest=3, push five words to dest 2 and one to dest 0 -> dest 2 count stops at 3 and the dest-0 word stays in main until pop[2]; main_pause rises when main count reaches 6.
- Overflow: with no pops and all heads blocked, push 9 words into DEPTH=8 -> 9th dropped, error_out=1 next cycle, state=4, held until reset.
- Underflow: pop[1]=1 with can_pop[1]=0 -> state ERROR, data_out slice 1 unchanged.
- Reset mid-traffic: reset=0 with 5 words buffered -> next cycle all counts 0, can_pop=0, data_out=0, state=RESET.

Source files
------------

// File: rtl/pcie_trans_pkg.sv
// Shared types and defaults for the PCIe transaction router.
// Holds FSM encodings and the destination-field helper.
package pcie_trans_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEST_BITS = 2;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_LENGTH    = 4;

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_INIT   = 4'd1,
    ST_IDLE   = 4'd2,
    ST_ACTIVE = 4'd3,
    ST_ERROR  = 4'd4
  } state_t;

  // Destination lives in the top DEST_BITS of the word.
  function automatic int unsigned dest_of(
    input logic [63:0] word,
    input int unsigned width,
    input int unsigned dbits
  );
    logic [63:0] sh;
    logic [63:0] mask;
    sh   = word >> (width - dbits);
    mask = (64'd1 << dbits) - 64'd1;
    return int'(sh & mask);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with occupancy count and error pulses.
// Push while full is accepted only if a pop frees a slot.
module fifo_sync
  import pcie_trans_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LENGTH = DEF_LENGTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic [LENGTH-1:0] count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == LENGTH'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign overflow  = push && full && !do_pop;
  assign underflow = pop && empty;
  assign data_out  = mem[rd_ptr];

  // Storage array; reset only clears bookkeeping.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pcie_trans_nch.sv
// PCIe transaction router: one main FIFO feeding N dests.
// Holds the supervisory FSM, router and threshold latches.
module pcie_trans_nch
  import pcie_trans_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEST_BITS = DEF_DEST_BITS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LENGTH    = DEF_LENGTH,
  localparam int NUM_DEST = 2 ** DEST_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      push,
  input  logic [NUM_DEST-1:0]       pop,
  input  logic [LENGTH-1:0]         umbral_main,
  input  logic [LENGTH-1:0]         umbral_dest,
  output logic [NUM_DEST*WIDTH-1:0] data_out,
  output logic [NUM_DEST-1:0]       can_pop,
  output logic                      main_pause,
  output logic                      error_out,
  output logic                      idle_out,
  output logic [3:0]                state,
  output logic [3:0]                next_state
);

  state_t st;
  state_t nst;

  logic [LENGTH-1:0] th_main;
  logic [LENGTH-1:0] th_dest;
  logic              op;

  logic [WIDTH-1:0]  m_head;
  logic [LENGTH-1:0] m_count;
  logic              m_empty;
  logic              m_full;
  logic              m_ovf;
  logic              m_unf;
  logic              m_push;

  logic [DEST_BITS-1:0] head_dest;
  logic                 xfer;

  logic [WIDTH-1:0]    d_head  [NUM_DEST];
  logic [LENGTH-1:0]   d_count [NUM_DEST];
  logic [WIDTH-1:0]    dout    [NUM_DEST];
  logic [NUM_DEST-1:0] d_empty;
  logic [NUM_DEST-1:0] d_full;
  logic [NUM_DEST-1:0] d_ovf;
  logic [NUM_DEST-1:0] d_unf;
  logic [NUM_DEST-1:0] d_push;
  logic [NUM_DEST-1:0] d_pop;

  logic err_evt;
  logic any_ne;
  logic unused;

  assign op = (st == ST_IDLE) || (st == ST_ACTIVE)
           || (st == ST_ERROR);

  assign m_push = push && op;
  assign d_pop  = pop & {NUM_DEST{op}};

  assign head_dest = DEST_BITS'(
    dest_of(64'(m_head), WIDTH, DEST_BITS));

  // Strict head-of-line: only the head may move.
  assign xfer = op && !m_empty
             && (d_count[head_dest] < th_dest);

  fifo_sync #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .LENGTH (LENGTH)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .push      (m_push),
    .pop       (xfer),
    .data_in   (data_in),
    .data_out  (m_head),
    .count     (m_count),
    .empty     (m_empty),
    .full      (m_full),
    .overflow  (m_ovf),
    .underflow (m_unf)
  );

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
    assign d_push[g] = xfer
      && (head_dest == DEST_BITS'(g));

    fifo_sync #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .LENGTH (LENGTH)
    ) u_dest (
      .clk       (clk),
      .reset     (reset),
      .push      (d_push[g]),
      .pop       (d_pop[g]),
      .data_in   (m_head),
      .data_out  (d_head[g]),
      .count     (d_count[g]),
      .empty     (d_empty[g]),
      .full      (d_full[g]),
      .overflow  (d_ovf[g]),
      .underflow (d_unf[g])
    );

    assign data_out[g*WIDTH +: WIDTH] = dout[g];
  end

  // Popped words are registered per destination.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DEST; i++)
        dout[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++)
        if (d_pop[i] && !d_empty[i])
          dout[i] <= d_head[i];
    end
  end

  // Thresholds follow the inputs while init is held in INIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th_main <= '0;
      th_dest <= '0;
    end else if (st == ST_INIT && init) begin
      th_main <= umbral_main;
      th_dest <= umbral_dest;
    end
  end

  assign err_evt = m_ovf || m_unf || (|d_ovf) || (|d_unf);
  assign any_ne  = !m_empty || !(&d_empty);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) st <= ST_RESET;
    else        st <= nst;
  end

  // Next-state logic; ERROR holds until reset.
  always_comb begin
    nst = st;
    unique case (st)
      ST_RESET: nst = ST_INIT;
      ST_INIT:  if (!init) nst = ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (err_evt)     nst = ST_ERROR;
        else if (any_ne) nst = ST_ACTIVE;
        else             nst = ST_IDLE;
      end
      ST_ERROR: nst = ST_ERROR;
      default:  nst = ST_RESET;
    endcase
  end

  assign state      = st;
  assign next_state = nst;
  assign can_pop    = ~d_empty;
  assign main_pause = op && (m_count >= th_main);
  assign error_out  = (st == ST_ERROR);
  assign idle_out   = (st == ST_IDLE);

  assign unused = &{1'b0, m_full, d_full};

endmodule

// File: tb/tb_pcie_trans_nch.sv
// Bench for pcie_trans_nch: queue model plus directed vectors.
// Outputs compared against the model every cycle.
module tb_pcie_trans_nch;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [7:0]  data_in;
  logic        push;
  logic [3:0]  pop;
  logic [3:0]  umbral_main;
  logic [3:0]  umbral_dest;
  logic [31:0] data_out;
  logic [3:0]  can_pop;
  logic        main_pause;
  logic        error_out;
  logic        idle_out;
  logic [3:0]  state;
  logic [3:0]  next_state;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  logic [7:0] mq [$];
  logic [7:0] dq [4][$];
  logic [7:0] md [4];
  logic [3:0] tm;
  logic [3:0] td;
  int         ms;

  always #5 clk = ~clk;

  pcie_trans_nch #(
    .WIDTH     (8),
    .DEST_BITS (2),
    .DEPTH     (8),
    .LENGTH    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .data_in     (data_in),
    .push        (push),
    .pop         (pop),
    .umbral_main (umbral_main),
    .umbral_dest (umbral_dest),
    .data_out    (data_out),
    .can_pop     (can_pop),
    .main_pause  (main_pause),
    .error_out   (error_out),
    .idle_out    (idle_out),
    .state       (state),
    .next_state  (next_state)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic m_step(input bit r, input bit in_i,
                        input bit p, input logic [7:0] d,
                        input logic [3:0] pp);
    bit         op;
    bit         ev;
    bit         xf;
    bit         pre_any;
    int         dst;
    logic [7:0] h;
    if (!r) begin
      mq.delete();
      for (int i = 0; i < 4; i++) begin
        dq[i].delete();
        md[i] = 8'h00;
      end
      tm = 0;
      td = 0;
      ms = 0;
      return;
    end
    op = (ms >= 2);
    pre_any = (mq.size() > 0);
    for (int i = 0; i < 4; i++)
      if (dq[i].size() > 0) pre_any = 1;
    ev  = 0;
    xf  = 0;
    dst = 0;
    h   = 8'h00;
    if (op) begin
      if (mq.size() > 0) begin
        h   = mq[0];
        dst = int'(h[7:6]);
        xf  = dq[dst].size() < int'(td);
      end
      for (int i = 0; i < 4; i++)
        if (pp[i]) begin
          if (dq[i].size() > 0) md[i] = dq[i].pop_front();
          else ev = 1;
        end
      if (xf) begin
        h = mq.pop_front();
        if (dq[dst].size() < 8) dq[dst].push_back(h);
        else ev = 1;
      end
      if (p) begin
        if (mq.size() < 8) mq.push_back(d);
        else ev = 1;
      end
    end
    case (ms)
      0: ms = 1;
      1: begin
        if (in_i) begin
          tm = umbral_main;
          td = umbral_dest;
        end else ms = 2;
      end
      2, 3: ms = ev ? 4 : (pre_any ? 3 : 2);
      default: ms = ms;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0]  ecp;
      logic [31:0] edo;
      for (int i = 0; i < 4; i++) begin
        ecp[i] = (dq[i].size() > 0);
        edo[i*8 +: 8] = md[i];
      end
      chk("can_pop", 64'(can_pop), 64'(ecp));
      chk("data_out", 64'(data_out), 64'(edo));
      chk("state", 64'(state), 64'(ms));
      chk("main_pause", 64'(main_pause),
          64'((ms >= 2) && (mq.size() >= int'(tm))));
      chk("error_out", 64'(error_out), 64'(ms == 4));
      chk("idle_out", 64'(idle_out), 64'(ms == 2));
    end
  end

  task automatic step(input bit r, input bit in_i,
                      input bit p, input logic [7:0] d,
                      input logic [3:0] pp);
    reset   = r;
    init    = in_i;
    push    = p;
    data_in = d;
    pop     = pp;
    m_step(r, in_i, p, d, pp);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 8'h00, 4'h0);
  endtask

  task automatic pushw(input logic [7:0] d);
    step(1, 0, 1, d, 4'h0);
  endtask

  task automatic bring_up(input logic [3:0] um,
                          input logic [3:0] ud);
    umbral_main = um;
    umbral_dest = ud;
    step(0, 0, 0, 8'h00, 4'h0);
    step(1, 1, 0, 8'h00, 4'h0);
    step(1, 1, 0, 8'h00, 4'h0);
    step(1, 0, 0, 8'h00, 4'h0);
  endtask

  task automatic drain(input int n);
    logic [3:0] m;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) m[i] = (dq[i].size() > 0);
      step(1, 0, 0, 8'h00, m);
    end
  endtask

  initial begin
    reset = 0; init = 0; push = 0; pop = 0;
    data_in = 0; umbral_main = 6; umbral_dest = 3;

    // reset and init
    step(0, 0, 0, 8'h00, 4'h0);
    chk_en = 1;
    step(0, 0, 0, 8'h00, 4'h0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_outs", 64'({can_pop, main_pause, error_out,
        idle_out}), 64'd0);
    chk("rst_dout", 64'(data_out), 64'd0);
    step(1, 1, 0, 8'h00, 4'h0);
    chk("init_state", 64'(state), 64'd1);
    step(1, 1, 0, 8'h00, 4'h0);
    step(1, 0, 0, 8'h00, 4'h0);
    chk("idle_state", 64'(state), 64'd2);
    chk("idle_out", 64'(idle_out), 64'd1);

    // routing to all four destinations
    pushw(8'h05);
    chk("route_c1", 64'(can_pop), 64'h0);
    pushw(8'h4A);
    chk("route_c2", 64'(can_pop), 64'h1);
    pushw(8'h8F);
    chk("route_c3", 64'(can_pop), 64'h3);
    pushw(8'hC3);
    chk("route_c4", 64'(can_pop), 64'h7);
    idle(1);
    chk("route_c5", 64'(can_pop), 64'hF);
    step(1, 0, 0, 8'h00, 4'hF);
    chk("route_dout", 64'(data_out), 64'hC38F4A05);
    idle(2);
    chk("route_idle", 64'(state), 64'd2);

    // head-of-line blocking and pause threshold
    pushw(8'h80); pushw(8'h81); pushw(8'h82);
    pushw(8'h83); pushw(8'h84); pushw(8'h01);
    pushw(8'hC0); pushw(8'hC1);
    chk("hol_nopause", 64'(main_pause), 64'd0);
    pushw(8'hC2);
    chk("hol_pause", 64'(main_pause), 64'd1);
    chk("hol_canpop", 64'(can_pop), 64'h4);
    step(1, 0, 0, 8'h00, 4'h4);
    chk("hol_pop2", 64'(data_out[23:16]), 64'h80);
    drain(30);
    idle(2);
    chk("hol_idle", 64'(state), 64'd2);

    // overflow with every head blocked
    pushw(8'h80); pushw(8'h81); pushw(8'h82);
    for (int i = 0; i < 8; i++) pushw(8'h90 + 8'(i));
    chk("ovf_pre", 64'(state), 64'd3);
    pushw(8'h98);
    chk("ovf_state", 64'(state), 64'd4);
    chk("ovf_err", 64'(error_out), 64'd1);
    idle(3);
    chk("ovf_sticky", 64'(state), 64'd4);

    // reset mid-traffic
    step(0, 0, 0, 8'h00, 4'h0);
    chk("mid_rst", 64'({state, can_pop, main_pause}),
        64'd0);
    chk("mid_dout", 64'(data_out), 64'd0);

    // underflow keeps slice 1
    step(1, 1, 0, 8'h00, 4'h0);
    step(1, 1, 0, 8'h00, 4'h0);
    step(1, 0, 0, 8'h00, 4'h0);
    pushw(8'h4A);
    idle(3);
    step(1, 0, 0, 8'h00, 4'h2);
    chk("unf_pre", 64'(data_out[15:8]), 64'h4A);
    step(1, 0, 0, 8'h00, 4'h2);
    chk("unf_state", 64'(state), 64'd4);
    chk("unf_hold", 64'(data_out[15:8]), 64'h4A);

    // zero main threshold pauses even when empty
    bring_up(4'd0, 4'd3);
    chk("zero_idle", 64'(state), 64'd2);
    chk("zero_pause", 64'(main_pause), 64'd1);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
